// File: rtl/seg7_595_drv.sv
// Scans eight 7-segment digits through two cascaded 74HC595s, one 16-bit {seg, sel} word per digit slot.
// Define SEG7_LZ_BLANK_EN to blank leading zeros (digit 0 is never blanked).
module seg7_595_drv #(
  parameter int CLK_DIV   = 4,
  parameter int DIGIT_CYC = 25000
) (
  input  logic        clk_25M,
  input  logic        rstn,
  input  logic [31:0] disp_data,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_en,
  output logic        seg7_SH_CP,
  output logic        seg7_ST_CP,
  output logic        seg7_DS,
  output logic        frame_done
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(DIGIT_CYC);

  typedef enum logic [2:0] {WAIT, LOAD, SH_LO, SH_HI, LATCH_HI, LATCH_LO} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] slot_cnt;
  logic [2:0]    digit_idx;
  logic [2:0]    next_digit;
  logic [3:0]    bit_idx;
  logic [15:0]   word;
  logic          boot;
  logic [31:0]   data_s;
  logic [7:0]    dp_s;
  logic [7:0]    en_s;

  logic          tick;
  logic          slot_done;
  logic          load_go;
  logic [3:0]    nib_c;
  logic [7:0]    lz_c;
  logic          blank_c;
  logic [7:0]    seg_c;
  logic [15:0]   word_c;

  // Active-low g..a glyphs for hex 0-F.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero while no more-significant enabled digit is nonzero.
  function automatic logic [7:0] lz_mask(input logic [31:0] d, input logic [7:0] en);
    logic seen;
    lz_mask = 8'h00;
    seen    = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (en[i] && (d[4*i +: 4] != 4'h0)) seen = 1'b1;
      else if (en[i] && !seen) lz_mask[i] = 1'b1;
    end
  endfunction
`endif

  always_comb begin
    nib_c = data_s[4*digit_idx +: 4];
`ifdef SEG7_LZ_BLANK_EN
    lz_c = lz_mask(data_s, en_s);
`else
    lz_c = 8'h00;
`endif
    blank_c = !en_s[digit_idx] || lz_c[digit_idx];
    seg_c   = {~dp_s[digit_idx], blank_c ? 7'h7F : hex_glyph(nib_c)};
    word_c  = {seg_c, ~(8'h01 << digit_idx)};
  end

  // The slot counter alone may start a LOAD; everything else waits for a tick.
  assign tick       = (tick_cnt == TW'(CLK_DIV - 1));
  assign slot_done  = (slot_cnt == SW'(DIGIT_CYC - 1));
  assign load_go    = ((state == WAIT) && (slot_done || (boot && tick))) ||
                      ((state == LATCH_LO) && slot_done);
  assign next_digit = (state == LATCH_LO) ? digit_idx + 3'd1 : digit_idx;

  always_ff @(posedge clk_25M or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
      slot_cnt <= '0;
    end else begin
      tick_cnt <= (tick || load_go) ? '0 : tick_cnt + 1'b1;
      if (load_go)         slot_cnt <= '0;
      else if (!slot_done) slot_cnt <= slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_25M or negedge rstn) begin
    if (!rstn) begin
      state      <= WAIT;
      boot       <= 1'b1;
      digit_idx  <= '0;
      bit_idx    <= '0;
      word       <= '0;
      data_s     <= '0;
      dp_s       <= '0;
      en_s       <= '0;
      seg7_SH_CP <= 1'b0;
      seg7_ST_CP <= 1'b0;
      seg7_DS    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load_go) begin
        state     <= LOAD;
        boot      <= 1'b0;
        digit_idx <= next_digit;
        // Inputs are frozen once per frame so all eight digits agree.
        if (next_digit == 3'd0) begin
          data_s <= disp_data;
          dp_s   <= dp;
          en_s   <= digit_en;
        end
      end else begin
        case (state)
          LOAD: if (tick) begin
            word       <= word_c;
            bit_idx    <= 4'd15;
            seg7_DS    <= word_c[15];
            seg7_SH_CP <= 1'b0;
            state      <= SH_LO;
          end
          SH_LO: if (tick) begin
            seg7_SH_CP <= 1'b1;
            state      <= SH_HI;
          end
          SH_HI: if (tick) begin
            seg7_SH_CP <= 1'b0;
            if (bit_idx == 4'd0) begin
              seg7_ST_CP <= 1'b1;
              state      <= LATCH_HI;
            end else begin
              bit_idx <= bit_idx - 4'd1;
              word    <= {word[14:0], 1'b0};
              seg7_DS <= word[14];
              state   <= SH_LO;
            end
          end
          LATCH_HI: if (tick) begin
            seg7_ST_CP <= 1'b0;
            frame_done <= (digit_idx == 3'd7);
            state      <= LATCH_LO;
          end
          LATCH_LO: begin
            digit_idx <= digit_idx + 3'd1;
            state     <= WAIT;
          end
          WAIT:    ;
          default: state <= WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_595_drv.sv
// Bench for seg7_595_drv: behaves like the 74HC595 pair on the serial bus and checks every latched word.
module tb_seg7_595_drv;
  localparam int CLK_DIV   = 4;
  localparam int DIGIT_CYC = 200;

  logic        clk_25M = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] disp_data = 32'h0;
  logic [7:0]  dp = 8'h0;
  logic [7:0]  digit_en = 8'hFF;
  logic        sh, st, ds, fd;

  always #5 clk_25M = ~clk_25M;

  seg7_595_drv #(.CLK_DIV(CLK_DIV), .DIGIT_CYC(DIGIT_CYC)) dut (
    .clk_25M(clk_25M), .rstn(rstn), .disp_data(disp_data), .dp(dp), .digit_en(digit_en),
    .seg7_SH_CP(sh), .seg7_ST_CP(st), .seg7_DS(ds), .frame_done(fd)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Shift-register receiver and timing recorder.
  int cyc = 0;
  logic sh_prev = 1'b0, st_prev = 1'b0, fd_prev = 1'b0;
  logic [15:0] shreg = 16'h0;
  int edges = 0, rises = 0, last_rise = 0, gap_min = 1000000, gap_max = 0;
  int st_rise_cyc = 0, st_width = 0, n_latch = 0, fd_run = 0, fd_width = 0;
  logic [15:0] words_q[$];
  int edges_q[$], gmin_q[$], gmax_q[$], lat_q[$], fd_q[$];

  always @(negedge clk_25M) begin
    cyc++;
    if (sh !== sh_prev) begin
      edges++;
      if (sh) begin
        shreg = {shreg[14:0], ds};
        if (rises > 0) begin
          if (cyc - last_rise < gap_min) gap_min = cyc - last_rise;
          if (cyc - last_rise > gap_max) gap_max = cyc - last_rise;
        end
        rises++;
        last_rise = cyc;
      end
    end
    if (st && !st_prev) begin
      n_latch++;
      words_q.push_back(shreg);
      edges_q.push_back(edges);
      gmin_q.push_back(gap_min);
      gmax_q.push_back(gap_max);
      lat_q.push_back(cyc);
      edges = 0; rises = 0; gap_min = 1000000; gap_max = 0;
      st_rise_cyc = cyc;
    end
    if (!st && st_prev) st_width = cyc - st_rise_cyc;
    if (fd && !fd_prev) begin
      fd_q.push_back(cyc);
      fd_run = 0;
    end
    if (fd) fd_run++;
    else if (fd_prev) fd_width = fd_run;
    if (!rstn) begin
      edges = 0; rises = 0; gap_min = 1000000; gap_max = 0;
    end
    sh_prev = sh; st_prev = st; fd_prev = fd;
  end

  // Lit-segment patterns (1 = segment on, bit order g..a).
  localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [15:0] model_word(input logic [31:0] d, input logic [7:0] p,
                                             input logic [7:0] e, input int idx);
    logic [3:0] nib;
    logic [7:0] lit;
    logic       shown;
    logic       lead;
    nib   = d[4*idx +: 4];
    shown = e[idx];
    lead  = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
    for (int j = idx + 1; j < 8; j++)
      if (e[j] && (d[4*j +: 4] != 4'h0)) lead = 1'b0;
    if (idx > 0 && e[idx] && nib == 4'h0 && lead) shown = 1'b0;
`endif
    lit = {p[idx], shown ? LIT[nib] : 7'h00};
    return {~lit, ~(8'd1 << idx)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_25M);
    #1;
  endtask

  logic [15:0] w_last;
  int e_last, gmin_last, gmax_last, lat_last;

  task automatic get_word();
    int t;
    t = 0;
    while (words_q.size() == 0 && t < 3 * DIGIT_CYC) begin
      step(1);
      t++;
    end
    n_cmp++;
    assert (words_q.size() != 0) else begin
      n_fail++;
      $error("FAIL word_timeout: observed no latch after %0d cycles, expected one", t);
    end
    if (words_q.size() != 0) begin
      w_last    = words_q.pop_front();
      e_last    = edges_q.pop_front();
      gmin_last = gmin_q.pop_front();
      gmax_last = gmax_q.pop_front();
      lat_last  = lat_q.pop_front();
    end else begin
      w_last = 16'hxxxx;
    end
  endtask

  task automatic expect_digit(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e, input int idx);
    get_word();
    check($sformatf("word_d%0d", idx), 32'(w_last), 32'(model_word(d, p, e, idx)));
  endtask

  task automatic expect_frame(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    for (int i = 0; i < 8; i++) expect_digit(d, p, e, i);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int rel, n0, t;
  logic [31:0] rd;
  logic [7:0] rp, re;

  initial begin
    step(5);
    check("rst_sh", 32'(sh), 32'd0);
    check("rst_st", 32'(st), 32'd0);
    check("rst_ds", 32'(ds), 32'd0);
    check("rst_fd", 32'(fd), 32'd0);

    // Reset release: first word comes out on the first tick, not after a slot.
    disp_data = 32'h0000_0008; dp = 8'h00; digit_en = 8'hFF;
    rel = cyc;
    rstn = 1'b1;
    get_word();
    check("first_word", 32'(w_last), 32'h80FE);
    check("first_latency", 32'(lat_last - rel), 32'd137);
    check("sh_edges", 32'(e_last), 32'd32);
    check("sh_gap_min", 32'(gmin_last), 32'd8);
    check("sh_gap_max", 32'(gmax_last), 32'd8);
    step(CLK_DIV + 2);
    check("st_width", 32'(st_width), 32'd4);
    for (int i = 1; i < 8; i++) expect_digit(32'h8, 8'h00, 8'hFF, i);

    disp_data = 32'h1234_5678; dp = 8'h01; digit_en = 8'hFF;
    step(10);
    check("fd_count1", 32'(fd_q.size()), 32'd1);
    check("fd_after_latch", 32'(fd_q[fd_q.size()-1] - lat_last), 32'(CLK_DIV));
    check("fd_width", 32'(fd_width), 32'd1);
    get_word(); check("w29_d0", 32'(w_last), 32'h00FE);
    get_word(); check("w29_d1", 32'(w_last), 32'hF8FD);
    get_word(); check("w29_d2", 32'(w_last), 32'h82FB);
    get_word(); check("w29_d3", 32'(w_last), 32'h92F7);
    for (int i = 4; i < 8; i++) expect_digit(32'h1234_5678, 8'h01, 8'hFF, i);

    // Mid-frame input change must wait for the next frame.
    disp_data = 32'h0; dp = 8'h00; digit_en = 8'hFF;
    step(10);
    check("fd_period", 32'(fd_q[fd_q.size()-1] - fd_q[fd_q.size()-2]), 32'(8 * DIGIT_CYC));
    for (int i = 0; i < 3; i++) expect_digit(32'h0, 8'h00, 8'hFF, i);
    step(100);
    disp_data = 32'hFFFF_FFFF;
    for (int i = 3; i < 8; i++) expect_digit(32'h0, 8'h00, 8'hFF, i);
    get_word(); check("f_glyph_d0", 32'(w_last), 32'h8EFE);
    for (int i = 1; i < 8; i++) expect_digit(32'hFFFF_FFFF, 8'h00, 8'hFF, i);

    // Leading zeros.
    disp_data = 32'h0000_0042;
    expect_frame(32'h0000_0042, 8'h00, 8'hFF);
`ifdef SEG7_LZ_BLANK_EN
    check("lz_d7", 32'(w_last), 32'hFF7F);
`else
    check("lz_d7", 32'(w_last), 32'hC07F);
`endif

    // Disabled digit 0, dp on digit 1.
    disp_data = $urandom; dp = 8'h02; digit_en = 8'hFE;
    rd = disp_data;
    get_word(); check("blank_d0", 32'(w_last), 32'hFFFE);
    for (int i = 1; i < 8; i++) expect_digit(rd, 8'h02, 8'hFE, i);

    for (int f = 0; f < 3; f++) begin
      rd = $urandom; rp = 8'($urandom); re = 8'($urandom);
      disp_data = rd; dp = rp; digit_en = re;
      expect_frame(rd, rp, re);
    end

    // Reset in the middle of digit 3's shift.
    rd = $urandom; disp_data = rd; dp = 8'h00; digit_en = 8'hFF;
    for (int i = 0; i < 3; i++) expect_digit(rd, 8'h00, 8'hFF, i);
    t = 0;
    while (rises < 7 && t < 3 * DIGIT_CYC) begin
      step(1);
      t++;
    end
    check("mid_shift_reached", 32'(rises >= 7), 32'd1);
    n0 = n_latch;
    #2 rstn = 1'b0;
    #1;
    check("abort_sh", 32'(sh), 32'd0);
    check("abort_st", 32'(st), 32'd0);
    check("abort_ds", 32'(ds), 32'd0);
    check("abort_fd", 32'(fd), 32'd0);
    rd = $urandom; rp = 8'($urandom); re = 8'($urandom);
    disp_data = rd; dp = rp; digit_en = re;
    step(20);
    check("abort_no_latch", 32'(n_latch), 32'(n0));
    rel = cyc;
    rstn = 1'b1;
    expect_digit(rd, rp, re, 0);
    check("restart_latency", 32'(lat_last - rel), 32'd137);
    check("restart_one_latch", 32'(n_latch), 32'(n0 + 1));
    for (int i = 1; i < 8; i++) expect_digit(rd, rp, re, i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
